// File: rtl/if_fetch_mq.sv
// Instruction fetch with several outstanding requests, in-order PC tags,
// stale-response discard after redirects, and a small buffer toward decode.
module if_fetch_mq #(
   parameter logic [31:0] RESET_PC    = 32'h1c000000,
   parameter int          OUTSTANDING = 2,
   parameter int          BUF_DEPTH   = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   input  logic        br_taken_id,
   input  logic [31:0] br_target_id,
   input  logic        br_taken_exe,
   input  logic [31:0] br_target_exe,
   input  logic        exec_flush,
   input  logic [31:0] exec_pc,
   input  logic        ertn_flush,
   input  logic [31:0] ertn_pc,
   input  logic        id_allowin,
   output logic        if_to_id_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_exc
);

   localparam int TW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int BW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(OUTSTANDING - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BUF_DEPTH - 1);
   localparam logic [3:0]    B_FULL = 4'(BUF_DEPTH);
   localparam logic [2:0]    O_MAX  = 3'(OUTSTANDING);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [2:0]    inflight_q, inflight_d, inflight_n;
   logic [2:0]    discard_q, discard_d;
   logic          pend_q, pend_d;
   logic [31:0]   pend_pc_q, pend_pc_d;
   logic [1:0]    pend_lvl_q, pend_lvl_d;
   logic          adef_q, adef_d;
   logic          hang_q, hang_d;
   logic [31:0]   tag_q [OUTSTANDING];
   logic [31:0]   tag_d [OUTSTANDING];
   logic [TW-1:0] twp_q, twp_d, trp_q, trp_d;
   logic [31:0]   bpc_q [BUF_DEPTH];
   logic [31:0]   bpc_d [BUF_DEPTH];
   logic [31:0]   binst_q [BUF_DEPTH];
   logic [31:0]   binst_d [BUF_DEPTH];
   logic          bexc_q [BUF_DEPTH];
   logic          bexc_d [BUF_DEPTH];
   logic [BW-1:0] bwp_q, bwp_d, brp_q, brp_d;
   logic [3:0]    bcnt_q, bcnt_d;

   logic          redir;
   logic [31:0]   redir_pc;
   logic [1:0]    redir_lvl;
   logic          credit, acc, hang_now;
   logic          keep, adef_push, push, buf_pop;
   logic [3:0]    eff_cnt;

   always_comb begin
      redir_pc  = br_target_id;
      redir_lvl = 2'd0;
      if (exec_flush) begin
         redir_pc  = exec_pc;
         redir_lvl = 2'd3;
      end else if (ertn_flush) begin
         redir_pc  = ertn_pc;
         redir_lvl = 2'd2;
      end else if (br_taken_exe) begin
         redir_pc  = br_target_exe;
         redir_lvl = 2'd1;
      end
   end

   assign redir = exec_flush | ertn_flush | br_taken_exe | br_taken_id;

   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'b10;
   assign inst_sram_wstrb = 4'b0;
   assign inst_sram_wdata = 32'b0;
   assign inst_sram_addr  = fetch_pc_q;

   assign if_to_id_valid = ~reset & (bcnt_q != 4'd0) & ~redir;
   assign if_pc          = bpc_q[brp_q];
   assign if_inst        = binst_q[brp_q];
   assign if_exc         = bexc_q[brp_q];
   assign buf_pop        = if_to_id_valid & id_allowin;

   // The slot freed by this cycle's pop counts as free credit.
   assign eff_cnt = bcnt_q - {3'b0, buf_pop};
   assign credit  = (inflight_q < O_MAX) &
                    (({2'b0, inflight_q} + {1'b0, eff_cnt}) < 5'(BUF_DEPTH));

   assign inst_sram_req = ~reset &
                          (hang_q | ((fetch_pc_q[1:0] == 2'b00) & ~adef_q & credit));

   assign acc        = inst_sram_req & inst_sram_addr_ok;
   assign hang_now   = inst_sram_req & ~inst_sram_addr_ok;
   assign inflight_n = inflight_q + {2'b0, acc} - {2'b0, inst_sram_data_ok};

   assign keep      = inst_sram_data_ok & ~redir & (discard_q == 3'd0);
   assign adef_push = (fetch_pc_q[1:0] != 2'b00) & ~adef_q & ~hang_q &
                      (inflight_q == 3'd0) & (bcnt_q < B_FULL) & ~redir;
   assign push      = keep | adef_push;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_n;
      discard_d  = discard_q;
      pend_d     = pend_q;
      pend_pc_d  = pend_pc_q;
      pend_lvl_d = pend_lvl_q;
      adef_d     = adef_q | adef_push;
      hang_d     = hang_now;
      tag_d      = tag_q;
      twp_d      = twp_q;
      trp_d      = trp_q;
      bpc_d      = bpc_q;
      binst_d    = binst_q;
      bexc_d     = bexc_q;
      bwp_d      = bwp_q;
      brp_d      = brp_q;
      bcnt_d     = bcnt_q + {3'b0, push} - {3'b0, buf_pop};

      if (acc) begin
         tag_d[twp_q] = fetch_pc_q;
         twp_d = (twp_q == T_LAST) ? '0 : twp_q + 1'b1;
      end
      if (inst_sram_data_ok) begin
         trp_d = (trp_q == T_LAST) ? '0 : trp_q + 1'b1;
         if (discard_q != 3'd0) discard_d = discard_q - 3'd1;
      end

      if (push) begin
         bpc_d[bwp_q]   = keep ? tag_q[trp_q] : fetch_pc_q;
         binst_d[bwp_q] = keep ? inst_sram_rdata : 32'h0;
         bexc_d[bwp_q]  = ~keep;
         bwp_d = (bwp_q == B_LAST) ? '0 : bwp_q + 1'b1;
      end
      if (buf_pop) brp_d = (brp_q == B_LAST) ? '0 : brp_q + 1'b1;

      if (acc) begin
         if (pend_q) begin
            fetch_pc_d = pend_pc_q;
            discard_d  = inflight_n;
            pend_d     = 1'b0;
         end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
      end

      // Everything still in flight after a redirect is stale.
      if (redir) begin
         bcnt_d    = 4'd0;
         bwp_d     = '0;
         brp_d     = '0;
         discard_d = inflight_n;
         adef_d    = 1'b0;
         if (hang_now) begin
            pend_d = 1'b1;
            if (~pend_q | (redir_lvl >= pend_lvl_q)) begin
               pend_pc_d  = redir_pc;
               pend_lvl_d = redir_lvl;
            end
         end else begin
            fetch_pc_d = redir_pc;
            pend_d     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 3'd0;
         discard_q  <= 3'd0;
         pend_q     <= 1'b0;
         pend_pc_q  <= 32'h0;
         pend_lvl_q <= 2'd0;
         adef_q     <= 1'b0;
         hang_q     <= 1'b0;
         twp_q      <= '0;
         trp_q      <= '0;
         bwp_q      <= '0;
         brp_q      <= '0;
         bcnt_q     <= 4'd0;
         for (int i = 0; i < OUTSTANDING; i++) tag_q[i] <= 32'h0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            bpc_q[i]   <= 32'h0;
            binst_q[i] <= 32'h0;
            bexc_q[i]  <= 1'b0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         pend_lvl_q <= pend_lvl_d;
         adef_q     <= adef_d;
         hang_q     <= hang_d;
         twp_q      <= twp_d;
         trp_q      <= trp_d;
         bwp_q      <= bwp_d;
         brp_q      <= brp_d;
         bcnt_q     <= bcnt_d;
         tag_q      <= tag_d;
         bpc_q      <= bpc_d;
         binst_q    <= binst_d;
         bexc_q     <= bexc_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_mq.sv
// Bench for if_fetch_mq: directed scenarios plus randomized traffic checked
// against an expected-PC-stream model and an in-order memory responder.
module tb_if_fetch_mq;
   localparam logic [31:0] RST_PC = 32'h1c000000;
   localparam int OUTS = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        inst_sram_req, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr, inst_sram_wdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        br_taken_id, br_taken_exe, exec_flush, ertn_flush;
   logic [31:0] br_target_id, br_target_exe, exec_pc, ertn_pc;
   logic        id_allowin, if_to_id_valid, if_exc;
   logic [31:0] if_pc, if_inst;

   if_fetch_mq #(.RESET_PC(RST_PC), .OUTSTANDING(OUTS), .BUF_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata),
      .br_taken_id(br_taken_id), .br_target_id(br_target_id),
      .br_taken_exe(br_taken_exe), .br_target_exe(br_target_exe),
      .exec_flush(exec_flush), .exec_pc(exec_pc),
      .ertn_flush(ertn_flush), .ertn_pc(ertn_pc),
      .id_allowin(id_allowin), .if_to_id_valid(if_to_id_valid),
      .if_pc(if_pc), .if_inst(if_inst), .if_exc(if_exc)
   );

   int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0, n_rand_del = 0;
   int aok_mode, dok_mode, allow_mode, lat_min, lat_max;
   logic rst_v;
   logic r_exec, r_ertn, r_bexe, r_bid;
   logic [31:0] t_exec, t_ertn, t_bexe, t_bid;

   logic [31:0] rq_a[$];
   int          rq_t[$];

   logic [31:0] exp_pc;
   bit          adef_done, prev_hang, m_pend;
   int          m_lvl;
   logic [31:0] prev_addr;

   logic [31:0] iss_addr[$];
   int          iss_cyc[$];
   logic [31:0] del_pc[$];
   logic [31:0] del_inst[$];
   logic        del_exc[$];
   int          del_cyc[$];
   int          req_cnt;
   logic        last_valid, last_exc;
   logic [31:0] last_pc, last_inst;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h13579bdf;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr_logs();
      iss_addr.delete(); iss_cyc.delete();
      del_pc.delete(); del_inst.delete(); del_exc.delete(); del_cyc.delete();
      req_cnt = 0;
   endtask

   task automatic tick();
      logic redir, hang_now;
      logic [31:0] tgt;
      int lvl;
      @(negedge clk);
      reset = rst_v;
      inst_sram_addr_ok = (aok_mode == 2) ? ($urandom_range(0, 9) < 7) : (aok_mode == 1);
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = $urandom;
      if (dok_mode != 0 && rq_a.size() > 0 && rq_t[0] <= cyc &&
          (dok_mode == 1 || $urandom_range(0, 3) != 0)) begin
         inst_sram_data_ok = 1'b1;
         inst_sram_rdata   = mem_word(rq_a[0]);
      end
      id_allowin = (allow_mode == 2) ? ($urandom_range(0, 9) < 7) : (allow_mode == 1);
      exec_flush = r_exec; exec_pc = t_exec;
      ertn_flush = r_ertn; ertn_pc = t_ertn;
      br_taken_exe = r_bexe; br_target_exe = t_bexe;
      br_taken_id = r_bid; br_target_id = t_bid;
      #1;
      if (rst_v) begin
         check("rst_req", inst_sram_req, 0);
         check("rst_valid", if_to_id_valid, 0);
         rq_a.delete(); rq_t.delete();
         exp_pc = RST_PC; adef_done = 0; prev_hang = 0; m_pend = 0; m_lvl = 0;
      end else begin
         redir = r_exec | r_ertn | r_bexe | r_bid;
         tgt = r_exec ? t_exec : r_ertn ? t_ertn : r_bexe ? t_bexe : t_bid;
         lvl = r_exec ? 3 : r_ertn ? 2 : r_bexe ? 1 : 0;
         hang_now = inst_sram_req & ~inst_sram_addr_ok;
         last_valid = if_to_id_valid; last_pc = if_pc;
         last_inst = if_inst; last_exc = if_exc;
         if (redir) check("valid_on_redir", if_to_id_valid, 0);
         if (if_to_id_valid && id_allowin) begin
            del_pc.push_back(if_pc); del_inst.push_back(if_inst);
            del_exc.push_back(if_exc); del_cyc.push_back(cyc);
            n_rand_del++;
            if (adef_done) check("deliver_after_adef", if_to_id_valid, 0);
            else if (exp_pc[1:0] != 2'b00) begin
               check("adef_pc", if_pc, exp_pc);
               check("adef_exc", if_exc, 1);
               check("adef_inst", if_inst, 0);
               adef_done = 1;
            end else begin
               check("pc", if_pc, exp_pc);
               check("inst", if_inst, mem_word(exp_pc));
               check("exc", if_exc, 0);
               exp_pc = exp_pc + 32'd4;
            end
         end
         if (prev_hang) begin
            check("hold_req", inst_sram_req, 1);
            check("hold_addr", inst_sram_addr, prev_addr);
         end
         if (inst_sram_data_ok) begin
            void'(rq_a.pop_front()); void'(rq_t.pop_front());
         end
         if (inst_sram_req && inst_sram_addr_ok) begin
            rq_a.push_back(inst_sram_addr);
            rq_t.push_back(cyc + $urandom_range(lat_min, lat_max));
            iss_addr.push_back(inst_sram_addr); iss_cyc.push_back(cyc);
            check("outstanding", rq_a.size() <= OUTS, 1);
         end
         if (inst_sram_req) req_cnt++;
         if (redir) begin
            adef_done = 0;
            if (hang_now) begin
               if (!m_pend || lvl >= m_lvl) begin exp_pc = tgt; m_lvl = lvl; end
               m_pend = 1;
            end else begin
               exp_pc = tgt; m_pend = 0;
            end
         end else if (inst_sram_req && inst_sram_addr_ok) m_pend = 0;
         prev_hang = hang_now; prev_addr = inst_sram_addr;
      end
      r_exec = 0; r_ertn = 0; r_bexe = 0; r_bid = 0;
      cyc++;
      @(posedge clk);
   endtask

   task automatic do_reset();
      rst_v = 1'b1;
      repeat (2) tick();
      rst_v = 1'b0;
   endtask

   task automatic set_env(input int a, input int d, input int al,
                          input int lmin, input int lmax);
      aok_mode = a; dok_mode = d; allow_mode = al; lat_min = lmin; lat_max = lmax;
   endtask

   initial begin
      int s;
      r_exec = 0; r_ertn = 0; r_bexe = 0; r_bid = 0;
      t_exec = 0; t_ertn = 0; t_bexe = 0; t_bid = 0;
      reset = 1; inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = 0;
      id_allowin = 0; exec_flush = 0; ertn_flush = 0; br_taken_exe = 0; br_taken_id = 0;
      exec_pc = 0; ertn_pc = 0; br_target_exe = 0; br_target_id = 0;
      set_env(1, 1, 1, 1, 1);

      // back-to-back fetch, zero-latency delivery
      do_reset(); clr_logs();
      tick();
      check("post_rst_valid", last_valid, 0);
      check("post_rst_pc", last_pc, 0);
      check("post_rst_inst", last_inst, 0);
      check("post_rst_exc", last_exc, 0);
      check("const_wr", inst_sram_wr, 0);
      check("const_size", inst_sram_size, 2);
      check("const_wstrb", inst_sram_wstrb, 0);
      check("const_wdata", inst_sram_wdata, 0);
      repeat (6) tick();
      check("b2b_n_iss", iss_addr.size() >= 3, 1);
      check("b2b_n_del", del_pc.size() >= 3, 1);
      if (iss_addr.size() >= 3 && del_pc.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            check("b2b_addr", iss_addr[i], RST_PC + 32'(4 * i));
            check("b2b_cyc", iss_cyc[i] - iss_cyc[0], i);
            check("b2b_del", del_pc[i], RST_PC + 32'(4 * i));
         end
         check("b2b_latency", del_cyc[0] - iss_cyc[0], 2);
      end

      // data_ok withheld: only OUTSTANDING handshakes
      do_reset(); set_env(1, 0, 1, 1, 1); clr_logs();
      repeat (5) tick();
      check("hold_n_iss", iss_addr.size(), 2);
      check("hold_req_cycles", req_cnt, 2);
      dok_mode = 1; clr_logs();
      repeat (8) tick();
      check("hold_resume", del_pc.size() >= 2, 1);
      if (del_pc.size() >= 1) check("hold_first", del_pc[0], RST_PC);

      // branch with two in flight
      do_reset(); set_env(1, 1, 1, 6, 6);
      repeat (3) tick();
      r_bexe = 1; t_bexe = 32'h1c000100;
      tick();
      lat_min = 1; lat_max = 1; clr_logs();
      repeat (12) tick();
      check("br_n_del", del_pc.size() >= 2, 1);
      if (iss_addr.size() >= 1) check("br_first_addr", iss_addr[0], 32'h1c000100);
      if (del_pc.size() >= 1) check("br_first_del", del_pc[0], 32'h1c000100);

      // redirects while the request hangs
      do_reset(); set_env(0, 1, 1, 1, 1);
      tick();
      r_bid = 1; t_bid = 32'h1c000200;
      tick();
      r_exec = 1; t_exec = 32'h1c008000;
      tick();
      repeat (2) tick();
      aok_mode = 1; clr_logs();
      repeat (8) tick();
      check("hang_n_iss", iss_addr.size() >= 2, 1);
      if (iss_addr.size() >= 2) begin
         check("hang_addr0", iss_addr[0], RST_PC);
         check("hang_addr1", iss_addr[1], 32'h1c008000);
      end
      if (del_pc.size() >= 1) check("hang_first_del", del_pc[0], 32'h1c008000);

      // misaligned ertn target raises ADEF and stalls
      r_ertn = 1; t_ertn = 32'h1c000002;
      tick();
      clr_logs();
      repeat (10) tick();
      check("adef_n_del", del_pc.size(), 1);
      check("adef_n_iss", iss_addr.size(), 0);
      check("adef_stalled", last_valid, 0);
      if (del_pc.size() == 1) begin
         check("adef_log_pc", del_pc[0], 32'h1c000002);
         check("adef_log_exc", del_exc[0], 1);
         check("adef_log_inst", del_inst[0], 0);
      end
      r_bid = 1; t_bid = 32'h1c000040;
      tick();
      clr_logs();
      repeat (6) tick();
      check("adef_resume", iss_addr.size() >= 1, 1);
      if (iss_addr.size() >= 1) check("adef_resume_addr", iss_addr[0], 32'h1c000040);

      // decode stalled: buffer fills without overflow
      do_reset(); set_env(1, 1, 0, 1, 1); clr_logs();
      repeat (10) tick();
      check("full_n_iss", iss_addr.size(), 2);
      check("full_req_cycles", req_cnt, 2);
      check("full_valid", last_valid, 1);
      check("full_head", last_pc, RST_PC);
      allow_mode = 1; clr_logs();
      repeat (8) tick();
      check("full_n_del", del_pc.size() >= 4, 1);
      if (del_pc.size() >= 2) begin
         check("full_del0", del_pc[0], RST_PC);
         check("full_del1", del_pc[1], RST_PC + 32'd4);
      end

      // randomized traffic with a mid-run reset
      do_reset(); set_env(2, 2, 2, 1, 3);
      n_rand_del = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         if ($urandom_range(0, 99) < 3) begin
            s = $urandom_range(1, 15);
            r_bid = s[0]; r_bexe = s[1]; r_ertn = s[2]; r_exec = s[3];
            t_bid  = {16'h1c00, 4'h0, 10'($urandom_range(0, 1023)), 2'b00};
            t_bexe = {16'h1c00, 4'h1, 10'($urandom_range(0, 1023)), 2'b00};
            t_ertn = {16'h1c00, 4'h2, 10'($urandom_range(0, 1023)), 2'b00};
            t_exec = {16'h1c00, 4'h3, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 9) == 0) t_exec[1:0] = 2'($urandom_range(1, 3));
         end
         tick();
      end
      check("rand_progress", n_rand_del > 200, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
